// File: rtl/keypad_conditioner.sv
// Keypad input stage: synchronises, debounces and edge-detects eight buttons,
// then holds one one-hot hit until the game core acknowledges it.
module keypad_conditioner #(
    parameter int DEB_CYCLES = 20000,
    parameter int CNT_W      = 15
) (
    input  logic       clk,
    input  logic       RESET,
    input  logic [7:0] keypad,
    input  logic       ack,
    output logic [7:0] key_stable,
    output logic [7:0] key_pulse,
    output logic [7:0] key_onehot,
    output logic       key_valid,
    output logic       overrun
);

    typedef enum logic {
        IDLE,
        HELD
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [7:0]       sync1_q;
    logic [7:0]       sync2_q;
    logic [7:0]       stable_q;
    logic [7:0]       stable_d;
    logic [7:0]       stable_dly_q;
    logic [7:0]       pulse_q;
    logic [7:0]       pulse_d;
    logic [7:0]       first_d;
    logic [7:0]       onehot_q;
    logic [7:0]       onehot_d;
    logic             valid_q;
    logic             valid_d;
    logic             overrun_q;
    logic             overrun_d;
    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q [8];
    logic [CNT_W-1:0] cnt_d [8];

    // Counter only runs while the synchronised level disagrees with the
    // debounced one; any agreement restarts it from zero.
    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < 8; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    stable_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_ONE;
                end
            end
        end
    end

    // Rising edges of the debounced level, one cycle after they appear.
    assign pulse_d = stable_q & ~stable_dly_q;
    assign first_d = pulse_d & (~pulse_d + 8'd1);

    always_comb begin
        state_d   = state_q;
        onehot_d  = onehot_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        unique case (state_q)
            IDLE: begin
                if (|pulse_d) begin
                    onehot_d = first_d;
                    valid_d  = 1'b1;
                    state_d  = HELD;
                end
            end
            HELD: begin
                if (ack && (|pulse_d)) begin
                    onehot_d  = first_d;
                    valid_d   = 1'b1;
                    overrun_d = 1'b0;
                end else if (ack) begin
                    onehot_d  = 8'd0;
                    valid_d   = 1'b0;
                    overrun_d = 1'b0;
                    state_d   = IDLE;
                end else if (|pulse_d) begin
                    overrun_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            sync1_q      <= 8'd0;
            sync2_q      <= 8'd0;
            stable_q     <= 8'd0;
            stable_dly_q <= 8'd0;
            pulse_q      <= 8'd0;
            onehot_q     <= 8'd0;
            valid_q      <= 1'b0;
            overrun_q    <= 1'b0;
            state_q      <= IDLE;
            for (int i = 0; i < 8; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q      <= keypad;
            sync2_q      <= sync1_q;
            stable_q     <= stable_d;
            stable_dly_q <= stable_q;
            pulse_q      <= pulse_d;
            onehot_q     <= onehot_d;
            valid_q      <= valid_d;
            overrun_q    <= overrun_d;
            state_q      <= state_d;
            for (int i = 0; i < 8; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign key_stable = stable_q;
    assign key_pulse  = pulse_q;
    assign key_onehot = onehot_q;
    assign key_valid  = valid_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_keypad_conditioner.sv
// Directed bench for keypad_conditioner with a short debounce window.
module tb_keypad_conditioner;

    logic       clk;
    logic       RESET;
    logic [7:0] keypad;
    logic       ack;
    logic [7:0] key_stable;
    logic [7:0] key_pulse;
    logic [7:0] key_onehot;
    logic       key_valid;
    logic       overrun;

    int n_chk  = 0;
    int n_fail = 0;

    keypad_conditioner #(
        .DEB_CYCLES(4),
        .CNT_W(3)
    ) dut (
        .clk(clk),
        .RESET(RESET),
        .keypad(keypad),
        .ack(ack),
        .key_stable(key_stable),
        .key_pulse(key_pulse),
        .key_onehot(key_onehot),
        .key_valid(key_valid),
        .overrun(overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic [7:0] kp;
        logic       ack;
        logic [7:0] e_stable;
        logic [7:0] e_pulse;
        logic [7:0] e_onehot;
        logic       e_valid;
        logic       e_ovr;
        string      tag;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic r, logic [7:0] k, logic a,
                                logic [7:0] s, logic [7:0] p,
                                logic [7:0] o, logic v, logic ov,
                                string t);
        vec_t x;
        x.rst_n = r; x.kp = k; x.ack = a;
        x.e_stable = s; x.e_pulse = p; x.e_onehot = o;
        x.e_valid = v; x.e_ovr = ov; x.tag = t;
        return x;
    endfunction

    task automatic chk(string name, logic [7:0] got, logic [7:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic chk_all(string t, logic [7:0] s, logic [7:0] p,
                           logic [7:0] o, logic v, logic ov);
        chk({t, ".stable"}, key_stable, s);
        chk({t, ".pulse"}, key_pulse, p);
        chk({t, ".onehot"}, key_onehot, o);
        chk({t, ".valid"}, 8'(key_valid), 8'(v));
        chk({t, ".overrun"}, 8'(overrun), 8'(ov));
    endtask

    task automatic step(int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        RESET  = 1'b0;
        keypad = 8'hFF;
        ack    = 1'b0;

        // Reset with all keys down, then release and debounce them
        for (int k = 0; k < 2; k++)
            vecs.push_back(mk(0, 8'hFF, 0, 0, 0, 0, 0, 0, "rst"));
        for (int k = 0; k < 5; k++)
            vecs.push_back(mk(1, 8'hFF, 0, 0, 0, 0, 0, 0, "rel"));
        vecs.push_back(mk(1, 8'hFF, 0, 8'hFF, 0, 0, 0, 0, "rel6"));
        vecs.push_back(mk(1, 8'hFF, 0, 8'hFF, 8'hFF, 8'h01, 1, 0, "rel7"));
        vecs.push_back(mk(1, 8'hFF, 0, 8'hFF, 0, 8'h01, 1, 0, "rel8"));
        vecs.push_back(mk(1, 8'hFF, 1, 8'hFF, 0, 0, 0, 0, "ack_ff"));
        vecs.push_back(mk(1, 8'hFF, 0, 8'hFF, 0, 0, 0, 0, "idle_ff"));
        for (int k = 0; k < 5; k++)
            vecs.push_back(mk(1, 8'h00, 0, 8'hFF, 0, 0, 0, 0, "up_ff"));
        vecs.push_back(mk(1, 8'h00, 0, 8'h00, 0, 0, 0, 0, "up_ff6"));
        // Glitch: 3 high, 1 low, 3 high
        for (int k = 0; k < 3; k++)
            vecs.push_back(mk(1, 8'h08, 0, 0, 0, 0, 0, 0, "gl_a"));
        vecs.push_back(mk(1, 8'h00, 0, 0, 0, 0, 0, 0, "gl_gap"));
        for (int k = 0; k < 3; k++)
            vecs.push_back(mk(1, 8'h08, 0, 0, 0, 0, 0, 0, "gl_b"));
        for (int k = 0; k < 6; k++)
            vecs.push_back(mk(1, 8'h00, 0, 0, 0, 0, 0, 0, "gl_tail"));
        // Clean press of key5 with ack
        for (int k = 0; k < 5; k++)
            vecs.push_back(mk(1, 8'h20, 0, 0, 0, 0, 0, 0, "k5"));
        vecs.push_back(mk(1, 8'h20, 0, 8'h20, 0, 0, 0, 0, "k5_st"));
        vecs.push_back(mk(1, 8'h20, 0, 8'h20, 8'h20, 8'h20, 1, 0, "k5_pl"));
        vecs.push_back(mk(1, 8'h20, 0, 8'h20, 0, 8'h20, 1, 0, "k5_hold"));
        vecs.push_back(mk(1, 8'h20, 1, 8'h20, 0, 0, 0, 0, "k5_ack"));
        for (int k = 0; k < 5; k++)
            vecs.push_back(mk(1, 8'h00, 0, 8'h20, 0, 0, 0, 0, "k5_up"));
        vecs.push_back(mk(1, 8'h00, 0, 8'h00, 0, 0, 0, 0, "k5_up6"));

        #3;
        chk_all("async_rst", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < vecs.size(); i++) begin
            RESET  = vecs[i].rst_n;
            keypad = vecs[i].kp;
            ack    = vecs[i].ack;
            step(1);
            chk_all($sformatf("%s[%0d]", vecs[i].tag, i), vecs[i].e_stable,
                    vecs[i].e_pulse, vecs[i].e_onehot, vecs[i].e_valid,
                    vecs[i].e_ovr);
        end
        ack = 1'b0;

        // Overrun: key2 held as hit, key6 dropped
        keypad = 8'h04;
        step(7);
        chk_all("ovr_k2", 8'h04, 8'h04, 8'h04, 1'b1, 1'b0);
        keypad = 8'h00;
        step(8);
        keypad = 8'h40;
        step(7);
        chk_all("ovr_k6", 8'h40, 8'h40, 8'h04, 1'b1, 1'b1);
        ack = 1'b1;
        step(1);
        ack = 1'b0;
        chk_all("ovr_ack", 8'h40, 8'h00, 8'h00, 1'b0, 1'b0);

        // Simultaneous key1+key3: lowest wins, no overrun
        keypad = 8'h4A;
        step(7);
        chk_all("simul", 8'h4A, 8'h0A, 8'h02, 1'b1, 1'b0);
        keypad = 8'h4B;
        step(7);
        chk_all("ovr_k0", 8'h4B, 8'h01, 8'h02, 1'b1, 1'b1);
        // Ack coincides with key7 pulse
        keypad = 8'hCB;
        step(6);
        ack = 1'b1;
        step(1);
        ack = 1'b0;
        chk_all("same_ack", 8'hCB, 8'h80, 8'h80, 1'b1, 1'b0);
        step(1);
        chk_all("same_after", 8'hCB, 8'h00, 8'h80, 1'b1, 1'b0);

        // Reset while hit held and key4 mid-debounce
        keypad = 8'h00;
        step(8);
        chk_all("pre_rst", 8'h00, 8'h00, 8'h80, 1'b1, 1'b0);
        keypad = 8'h10;
        step(3);
        #2;
        RESET = 1'b0;
        #1;
        chk_all("mid_rst", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        step(2);
        chk_all("mid_rst_hold", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        RESET = 1'b1;
        step(5);
        chk_all("post5", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        step(1);
        chk_all("post6", 8'h10, 8'h00, 8'h00, 1'b0, 1'b0);
        step(1);
        chk_all("post7", 8'h10, 8'h10, 8'h10, 1'b1, 1'b0);
        step(1);
        chk_all("post8", 8'h10, 8'h00, 8'h10, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
